// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b types: word and cache-line vectors plus the cache arbiter state
// and grant encodings used by the I/D memory arbiter.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam int LC3B_LINE_W = 128;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_SERVE_I = 3'd1,
    ARB_SERVE_D = 3'd2,
    ARB_DONE_I  = 3'd3,
    ARB_DONE_D  = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_e;

  // On a tie the side that was not granted last wins.
  function automatic logic tie_picks_d(input arb_grant_e last_grant);
    return (last_grant == GRANT_I);
  endfunction

endpackage

// File: rtl/cache_arbiter_checker.sv
// Protocol properties of the cache arbiter outputs: mutually exclusive
// strobes and completions, and completions that last a single cycle.
module cache_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic i_resp,
  input logic d_resp,
  input logic pmem_read,
  input logic pmem_write
);

  resp_exclusive_a: assert property (@(posedge clk) disable iff (rst)
    !(i_resp && d_resp));

  strobe_exclusive_a: assert property (@(posedge clk) disable iff (rst)
    !(pmem_read && pmem_write));

  i_resp_single_a: assert property (@(posedge clk) disable iff (rst)
    i_resp |=> !i_resp);

  d_resp_single_a: assert property (@(posedge clk) disable iff (rst)
    d_resp |=> !d_resp);

endmodule

// File: rtl/cache_arbiter_register.sv
// Generic loadable register with synchronous active-high reset to zero.
module register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_r;

  // Capture data_in when load is high, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {WIDTH{1'b0}};
    end else if (load) begin
      data_r <= data_in;
    end else begin
      data_r <= data_r;
    end
  end

  assign data_out = data_r;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one physical
// memory port, alternating grants on ties so neither side starves.
import lc3b_types::*;

module cache_arbiter #(
  parameter int ADDR_W = $bits(lc3b_word),
  parameter int LINE_W = $bits(lc3b_line)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_e        state_r;
  arb_state_e        state_next_s;
  arb_grant_e        last_grant_r;
  logic              i_pend_s;
  logic              d_pend_s;
  logic              grant_i_s;
  logic              grant_d_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              pmem_read_r;
  logic              pmem_write_r;
  logic              i_resp_r;
  logic              d_resp_r;
  logic              pmem_read_next_s;
  logic              pmem_write_next_s;
  logic              i_resp_next_s;
  logic              d_resp_next_s;
  logic              buf_load_s;
  logic [LINE_W-1:0] line_buf_s;

  assign i_pend_s = i_read;
  assign d_pend_s = d_read | d_write;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and grant selection.
  always_comb begin
    state_next_s = state_r;
    grant_i_s    = 1'b0;
    grant_d_s    = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (d_pend_s && (!i_pend_s || tie_picks_d(last_grant_r))) begin
          grant_d_s    = 1'b1;
          state_next_s = ARB_SERVE_D;
        end else if (i_pend_s) begin
          grant_i_s    = 1'b1;
          state_next_s = ARB_SERVE_I;
        end else begin
          state_next_s = ARB_IDLE;
        end
      end
      ARB_SERVE_I: begin
        if (pmem_resp) begin
          state_next_s = ARB_DONE_I;
        end else begin
          state_next_s = ARB_SERVE_I;
        end
      end
      ARB_SERVE_D: begin
        if (pmem_resp) begin
          state_next_s = ARB_DONE_D;
        end else begin
          state_next_s = ARB_SERVE_D;
        end
      end
      ARB_DONE_I: state_next_s = ARB_IDLE;
      ARB_DONE_D: state_next_s = ARB_IDLE;
      default:    state_next_s = ARB_IDLE;
    endcase
  end

  // Next values of the registered strobes and completions.
  always_comb begin
    pmem_read_next_s  = 1'b0;
    pmem_write_next_s = 1'b0;
    i_resp_next_s     = 1'b0;
    d_resp_next_s     = 1'b0;
    buf_load_s        = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (grant_d_s) begin
          // A simultaneous read and write request is treated as a write.
          pmem_read_next_s  = ~d_write;
          pmem_write_next_s = d_write;
        end else if (grant_i_s) begin
          pmem_read_next_s  = 1'b1;
        end else begin
          pmem_read_next_s  = 1'b0;
          pmem_write_next_s = 1'b0;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (pmem_resp) begin
          buf_load_s    = pmem_read_r;
          i_resp_next_s = (state_r == ARB_SERVE_I);
          d_resp_next_s = (state_r == ARB_SERVE_D);
        end else begin
          pmem_read_next_s  = pmem_read_r;
          pmem_write_next_s = pmem_write_r;
        end
      end
      default: begin
        pmem_read_next_s  = 1'b0;
        pmem_write_next_s = 1'b0;
        i_resp_next_s     = 1'b0;
        d_resp_next_s     = 1'b0;
        buf_load_s        = 1'b0;
      end
    endcase
  end

  // Output registers and the request latch captured on the granting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
      i_resp_r     <= 1'b0;
      d_resp_r     <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {LINE_W{1'b0}};
      last_grant_r <= GRANT_I;
    end else begin
      pmem_read_r  <= pmem_read_next_s;
      pmem_write_r <= pmem_write_next_s;
      i_resp_r     <= i_resp_next_s;
      d_resp_r     <= d_resp_next_s;
      if (grant_d_s) begin
        addr_r       <= d_addr;
        wdata_r      <= d_wdata;
        last_grant_r <= GRANT_D;
      end else if (grant_i_s) begin
        addr_r       <= i_addr;
        last_grant_r <= GRANT_I;
      end else begin
        addr_r       <= addr_r;
        wdata_r      <= wdata_r;
        last_grant_r <= last_grant_r;
      end
    end
  end

  // One fill buffer serves both sides; only the side in DONE sees a resp.
  register #(.WIDTH(LINE_W)) u_line_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load_s),
    .data_in  (pmem_rdata),
    .data_out (line_buf_s)
  );

  cache_arbiter_checker u_checker (
    .clk        (clk),
    .rst        (rst),
    .i_resp     (i_resp_r),
    .d_resp     (d_resp_r),
    .pmem_read  (pmem_read_r),
    .pmem_write (pmem_write_r)
  );

  assign pmem_read    = pmem_read_r;
  assign pmem_write   = pmem_write_r;
  assign pmem_address = addr_r;
  assign pmem_wdata   = wdata_r;
  assign i_resp       = i_resp_r;
  assign d_resp       = d_resp_r;
  assign i_rdata      = line_buf_s;
  assign d_rdata      = line_buf_s;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomised scoreboard bench for cache_arbiter: a transaction-level model
// predicts grant order and memory accesses; monitors compare DUT activity.
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] i_rdata, d_rdata;
  logic          i_resp, d_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            side;   // 0 = I, 1 = D
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } acc_t;

  acc_t          acc_q[$];
  acc_t          resp_q[$];
  logic [LW-1:0] rdata_q[$];

  int checks   = 0;
  int failures = 0;
  bit model_last = 1'b0;   // side granted last by the model
  int resp_delay = -1;     // <0 selects a random delay
  bit resp_en    = 1'b1;
  bit stale_req  = 1'b0;
  bit i_granted, d_granted, i_done, d_done;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s unexpected event at %0t", name, $time);
  endtask

  // Memory responder: answers each access after a delay, records fill data.
  initial begin
    int d;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (stale_req) begin
        pmem_resp = 1'b1;
        @(negedge clk); #1;
        pmem_resp = 1'b0;
        stale_req = 1'b0;
      end else if (!rst && resp_en && (pmem_read || pmem_write)) begin
        d = (resp_delay < 0) ? int'($urandom_range(0, 4)) : resp_delay;
        for (int k = 0; k < d; k++) begin
          @(negedge clk); #1;
          check("strobe_hold", pmem_read | pmem_write, 1'b1);
        end
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        pmem_resp  = 1'b1;
        if (pmem_read) rdata_q.push_back(pmem_rdata);
        @(negedge clk);
        check("resp_latency", i_resp | d_resp, 1'b1);
        #1 pmem_resp = 1'b0;
      end
    end
  end

  // Access monitor: compares each pmem access against the model's queue.
  initial begin
    bit   prev_strobe;
    bit   cur_valid;
    acc_t cur;
    prev_strobe = 1'b0;
    cur_valid   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_strobe = 1'b0;
        cur_valid   = 1'b0;
      end else begin
        if ((pmem_read || pmem_write) && !prev_strobe) begin
          if (acc_q.size() == 0) begin
            fail_evt("pmem_access");
            cur_valid = 1'b0;
          end else begin
            cur = acc_q.pop_front();
            cur_valid = 1'b1;
            if (cur.side) d_granted = 1'b1;
            else          i_granted = 1'b1;
          end
        end
        if ((pmem_read || pmem_write) && cur_valid) begin
          check("pmem_write", pmem_write, cur.is_wr);
          check("pmem_read", pmem_read, !cur.is_wr);
          check("pmem_address", pmem_address, cur.addr);
          if (cur.is_wr) check("pmem_wdata", pmem_wdata, cur.wdata);
        end
        prev_strobe = pmem_read || pmem_write;
      end
    end
  end

  // Response monitor: side, uniqueness and fill data of each completion.
  initial begin
    acc_t          e;
    logic [LW-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && (i_resp || d_resp)) begin
        check("resp_exclusive", i_resp & d_resp, 1'b0);
        if (resp_q.size() == 0) begin
          fail_evt("resp");
        end else begin
          e = resp_q.pop_front();
          check("d_resp_side", d_resp, e.side);
          check("i_resp_side", i_resp, !e.side);
          if (!e.is_wr) begin
            if (rdata_q.size() == 0) begin
              fail_evt("rdata_missing");
            end else begin
              exp = rdata_q.pop_front();
              check(e.side ? "d_rdata" : "i_rdata", e.side ? d_rdata : i_rdata, exp);
            end
          end
          if (e.side) d_done = 1'b1;
          else        i_done = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    acc_q.delete(); resp_q.delete(); rdata_q.delete();
    model_last = 1'b0;
  endtask

  // One request round; the model decides grant order from the arbitration rules.
  task automatic round(input bit ien, input bit den, input bit drd, input bit dwr,
                       input logic [AW-1:0] ia, input logic [AW-1:0] da,
                       input logic [LW-1:0] wd, input bit toggle);
    acc_t ai, ad;
    bit   first_d;
    int   cyc;
    ai.side = 1'b0; ai.is_wr = 1'b0; ai.addr = ia; ai.wdata = '0;
    ad.side = 1'b1; ad.is_wr = dwr;  ad.addr = da; ad.wdata = wd;
    first_d = (ien && den) ? (model_last == 1'b0) : den;
    if (den && first_d) begin
      acc_q.push_back(ad); resp_q.push_back(ad); model_last = 1'b1;
      if (ien) begin acc_q.push_back(ai); resp_q.push_back(ai); model_last = 1'b0; end
    end else begin
      if (ien) begin acc_q.push_back(ai); resp_q.push_back(ai); model_last = 1'b0; end
      if (den) begin acc_q.push_back(ad); resp_q.push_back(ad); model_last = 1'b1; end
    end
    i_granted = 1'b0; d_granted = 1'b0;
    i_done = !ien; d_done = !den;
    i_read = ien; i_addr = ia;
    d_read = den & drd; d_write = den & dwr; d_addr = da; d_wdata = wd;
    cyc = 0;
    while (!(i_done && d_done) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (i_done) i_read = 1'b0;
      if (d_done) begin d_read = 1'b0; d_write = 1'b0; end
      if (toggle && i_granted) i_addr = AW'($urandom);
      if (toggle && d_granted) begin
        d_addr  = AW'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (!(i_done && d_done)) begin
      fail_evt("round_timeout");
      do_reset();
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_serve();
    acc_t ai;
    resp_en = 1'b0;
    ai.side = 1'b0; ai.is_wr = 1'b0; ai.addr = 16'h0BEE; ai.wdata = '0;
    acc_q.push_back(ai);
    i_read = 1'b1; i_addr = 16'h0BEE;
    @(posedge clk); #1;
    @(negedge clk);
    check("strobe_after_grant", pmem_read, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; i_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1'b0;
    @(negedge clk);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_i_resp", i_resp, 1'b0);
    stale_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stale_no_i_resp", i_resp, 1'b0);
      check("stale_no_d_resp", d_resp, 1'b0);
    end
    acc_q.delete(); resp_q.delete(); rdata_q.delete();
    resp_en = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ien, den, tg;
    int            kind;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] wd;
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_pmem_read", pmem_read, 1'b0);
    check("reset_pmem_write", pmem_write, 1'b0);
    check("reset_i_resp", i_resp, 1'b0);
    check("reset_d_resp", d_resp, 1'b0);
    check("reset_pmem_address", pmem_address, '0);
    check("reset_pmem_wdata", pmem_wdata, '0);
    check("reset_i_rdata", i_rdata, '0);
    check("reset_d_rdata", d_rdata, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    resp_delay = 3;
    round(1'b1, 1'b0, 1'b0, 1'b0, 16'h1230, 16'h0000, '0, 1'b0);
    resp_delay = -1;

    do_reset();
    round(1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200, '0, 1'b0);
    round(1'b1, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0400, '0, 1'b0);

    round(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h4000, {16{8'hA5}}, 1'b0);

    resp_delay = 4;
    round(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h2222, '0, 1'b1);
    round(1'b1, 1'b1, 1'b0, 1'b1, 16'h5550, 16'h6660, {8{16'h3C5A}}, 1'b1);
    resp_delay = -1;

    round(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h7770, {4{32'hDEADBEEF}}, 1'b0);

    reset_mid_serve();

    resp_delay = 0;
    round(1'b1, 1'b1, 1'b1, 1'b0, 16'h1110, 16'h2220, '0, 1'b0);
    resp_delay = -1;

    for (int n = 0; n < 60; n++) begin
      ien  = 1'($urandom);
      den  = 1'($urandom);
      if (!ien && !den) ien = 1'b1;
      kind = $urandom_range(1, 3);
      tg   = 1'($urandom);
      ia   = AW'($urandom);
      da   = AW'($urandom);
      wd   = {$urandom, $urandom, $urandom, $urandom};
      round(ien, den, kind[0], kind[1], ia, da, wd, tg);
    end

    repeat (4) @(posedge clk);
    check("acc_q_drained", acc_q.size(), '0);
    check("resp_q_drained", resp_q.size(), '0);
    check("rdata_q_drained", rdata_q.size(), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory byte-address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width in bits.
REQ-003 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: i_read  in  1  I-cache line fill request; i_addr  in  ADDR_W  I-cache line address; i_rdata  out  LINE_W  fill data; i_resp  out  1  I-side completion.
REQ-005 SHALL have ports: d_read  in  1  D-cache line fill request; d_write  in  1  D-cache writeback request; d_addr  in  ADDR_W  D line address; d_wdata  in  LINE_W  writeback data; d_rdata  out  LINE_W  fill data; d_resp  out  1  D-side completion.
REQ-006 SHALL have ports: pmem_read  out  1; pmem_write  out  1; pmem_address  out  ADDR_W; pmem_wdata  out  LINE_W; pmem_rdata  in  LINE_W; pmem_resp  in  1  physical memory done.

Function
REQ-007 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
REQ-008 SHALL, in IDLE, grant D when only a D request is pending; grant I when only i_read is pending; stay in IDLE when none is pending.
REQ-009 SHALL, in IDLE with both sides pending, grant the side not granted last (last_grant flop); after reset last_grant = I, so D wins the first tie.
REQ-010 SHALL latch address, direction and d_wdata on the granting edge; requester changes after grant SHALL NOT affect pmem outputs.
REQ-011 SHALL treat d_read and d_write both high as a write.
REQ-012 SHALL assert pmem_read or pmem_write from a register, starting the cycle after the grant, and hold it until pmem_resp is sampled high.
REQ-013 SHALL, on pmem_resp in SERVE_x, drop pmem_read/pmem_write, register pmem_rdata (reads only) and move to DONE_x on the same edge.
REQ-014 SHALL assert i_resp or d_resp for exactly one cycle, in DONE_x, with i_rdata/d_rdata valid in that cycle; DONE_x always returns to IDLE.
REQ-015 SHALL ignore requests sampled during DONE_x, since requesters drop requests after resp.
REQ-016 SHALL give minimum latency of request at IDLE edge N -> pmem strobe in cycle N+1 -> resp in cycle M+1, where pmem_resp is sampled at edge M.
REQ-017 SHALL ignore pmem_resp in IDLE or DONE_x.
REQ-018 SHALL never assert i_resp and d_resp together, and never assert pmem_read and pmem_write together.
REQ-019 SHALL hold i_rdata/d_rdata stable outside DONE_x at their last registered value.
REQ-020 SHALL grant each side at least every second grant while both stay pending, so no starvation.

Reset
REQ-021 SHALL, on rst high at a clk edge, go to IDLE with last_grant = I, all strobe and resp outputs 0, pmem_address 0, pmem_wdata 0, i_rdata 0 and d_rdata 0.
REQ-022 SHALL, on reset mid-transaction, abandon the in-flight pmem access with no resp issued; a later stale pmem_resp falls under REQ-017.

Structure
REQ-023 SHALL take lc3b_word and a new lc3b_line (LINE_W) typedef, plus the arbiter state enum, from lc3b_types.
REQ-024 SHALL implement grant selection and FSM inline; the shared read-data buffer SHALL reuse the existing generic register module at width LINE_W.

Verification
REQ-025 SHALL check I-only: i_read=1, i_addr=0x1230, pmem_resp after 3 cycles -> pmem_read with address 0x1230, one-cycle i_resp carrying pmem_rdata.
REQ-026 SHALL check simultaneous requests after reset: i_read=1 and d_read=1 -> D served first, then I; a further tie serves D again (alternation).
REQ-027 SHALL check D writeback: d_write=1, d_addr=0x4000, d_wdata=0xA5..A5 -> pmem_write=1 with latched data, d_resp one cycle, pmem_read stays 0.
REQ-028 SHALL check request change after grant: d_addr toggled mid-SERVE_D -> pmem_address unchanged.
REQ-029 SHALL check reset mid SERVE_I, then pmem_resp=1 -> no i_resp; strobes are 0 the cycle after reset.
REQ-030 SHALL check d_read=1 and d_write=1 together -> write performed, no read strobe.
